// File: rtl/dance_sequencer.sv
// dance_sequencer
//   Drives the 18-LED bank with one of four step patterns chosen by switches.
//   A prescaler divides Clock into step ticks. A request for a different mode
//   only takes effect when the running pattern comes back to its start state,
//   so a pattern never tears. The restart switch loads the requested mode at once.
//
// Ports
//   Clock       : system clock, rising edge
//   Resetn      : asynchronous active-low reset
//   SW[1:0]     : requested mode (00 LEFT, 01 RIGHT, 10 BOUNCE, 11 INVERT)
//   SW[3:2]     : speed, step period = DIV_BASE << (3 - SW[3:2])
//   SW[4]       : run enable
//   SW[5]       : restart (level)
//   SW[17:6]    : unused
//   led         : registered LED pattern
//   mode        : registered active mode
//   step        : one-cycle pulse, coincident with each led update
//   cycle_done  : one-cycle pulse when the pattern returns to its start state
module dance_sequencer #(
    parameter int N_LED    = 18,
    parameter int DIV_BASE = 6250000,
    parameter int CNT_W    = 26
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic [17:0]      SW,
    output logic [N_LED-1:0] led,
    output logic [1:0]       mode,
    output logic             step,
    output logic             cycle_done
);
    localparam int               POS_W    = $clog2(N_LED);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_LED - 1);

    typedef enum logic [1:0] {
        M_LEFT   = 2'b00,
        M_RIGHT  = 2'b01,
        M_BOUNCE = 2'b10,
        M_INVERT = 2'b11
    } mode_t;

    typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;
    typedef enum logic {PH_A = 1'b0, PH_B = 1'b1} phase_t;

    // State registers
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mode_t            mode_q, mode_d;
    logic [POS_W-1:0] pos_q, pos_d;
    dir_t             dir_q, dir_d;
    phase_t           phase_q, phase_d;
    logic [N_LED-1:0] led_q, led_d;
    logic             step_q, step_d;
    logic             done_q, done_d;

    // INVERT patterns: phase A lights even LEDs, phase B odd LEDs
    logic [N_LED-1:0] pat_a;
    logic [N_LED-1:0] pat_b;
    for (genvar gi = 0; gi < N_LED; gi++) begin : g_pat
        assign pat_a[gi] = ((gi % 2) == 0);
        assign pat_b[gi] = ((gi % 2) == 1);
    end

    logic unused_sw;
    assign unused_sw = ^SW[17:6];

    // Step period minus one, re-evaluated every cycle from the speed switches
    logic [1:0]       shift_amt;
    logic [CNT_W-1:0] period_m1;
    assign shift_amt = 2'd3 - SW[3:2];
    assign period_m1 = (CNT_W'(DIV_BASE) << shift_amt) - CNT_W'(1);

    // Requested mode and its start position
    mode_t            req_mode;
    logic [POS_W-1:0] req_pos;
    assign req_mode = mode_t'(SW[1:0]);
    assign req_pos  = (req_mode == M_RIGHT) ? POS_LAST : '0;

    // Next pattern state if a step fires, and whether it is the start state
    logic [POS_W-1:0] adv_pos;
    dir_t             adv_dir;
    phase_t           adv_phase;
    logic             adv_at_start;

    always_comb begin
        adv_pos      = pos_q;
        adv_dir      = dir_q;
        adv_phase    = phase_q;
        adv_at_start = 1'b0;
        case (mode_q)
            M_LEFT: begin
                adv_pos      = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
                adv_at_start = (adv_pos == '0);
            end
            M_RIGHT: begin
                adv_pos      = (pos_q == '0) ? POS_LAST : pos_q - POS_W'(1);
                adv_at_start = (adv_pos == POS_LAST);
            end
            M_BOUNCE: begin
                // Direction flips on arrival at an end, so each endpoint is shown once
                if (dir_q == DIR_UP) begin
                    adv_pos = pos_q + POS_W'(1);
                    if (adv_pos == POS_LAST) adv_dir = DIR_DOWN;
                end else begin
                    adv_pos = pos_q - POS_W'(1);
                    if (adv_pos == '0) adv_dir = DIR_UP;
                end
                adv_at_start = (adv_pos == '0) && (adv_dir == DIR_UP);
            end
            M_INVERT: begin
                adv_phase    = (phase_q == PH_A) ? PH_B : PH_A;
                adv_at_start = (adv_phase == PH_A);
            end
        endcase
    end

    // Next-state logic: restart beats stepping, disabled run freezes everything
    always_comb begin
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        phase_d = phase_q;
        step_d  = 1'b0;
        done_d  = 1'b0;
        if (SW[5]) begin
            cnt_d   = '0;
            mode_d  = req_mode;
            pos_d   = req_pos;
            dir_d   = DIR_UP;
            phase_d = PH_A;
        end else if (SW[4]) begin
            // >= so that switching to a shorter period fires immediately
            if (cnt_q >= period_m1) begin
                cnt_d  = '0;
                step_d = 1'b1;
                done_d = adv_at_start;
                if (adv_at_start && (req_mode != mode_q)) begin
                    mode_d  = req_mode;
                    pos_d   = req_pos;
                    dir_d   = DIR_UP;
                    phase_d = PH_A;
                end else begin
                    pos_d   = adv_pos;
                    dir_d   = adv_dir;
                    phase_d = adv_phase;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // LED image is always rebuilt from the next state, so nothing stale survives
    always_comb begin
        if (mode_d == M_INVERT) begin
            led_d = (phase_d == PH_A) ? pat_a : pat_b;
        end else begin
            led_d = N_LED'(1) << pos_d;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            cnt_q   <= '0;
            mode_q  <= M_LEFT;
            pos_q   <= '0;
            dir_q   <= DIR_UP;
            phase_q <= PH_A;
            led_q   <= N_LED'(1);
            step_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            phase_q <= phase_d;
            led_q   <= led_d;
            step_q  <= step_d;
            done_q  <= done_d;
        end
    end

    assign led        = led_q;
    assign mode       = mode_q;
    assign step       = step_q;
    assign cycle_done = done_q;

endmodule

// File: doc/dance_sequencer.md
Name: dance_sequencer

Overview:
- Controller for the 18-LED display on the board switch/LED bank.
- Divides the board clock into step ticks and runs one of four LED patterns selected by switches.
- Mode changes are deferred to pattern-cycle boundaries so a running pattern never tears mid-sequence; a restart switch forces an immediate change.
- Sits between the switch inputs and the LED outputs, replacing free-running single-pattern chasers.

Parameters:
- N_LED, 18, number of LEDs driven; position range 0..N_LED-1.
- DIV_BASE, 6250000, base prescaler period in clocks; sim benches use 4.
- CNT_W, 26, prescaler width; must hold DIV_BASE*8-1.

Ports:
- Clock  input  1  system clock, rising edge.
- Resetn  input  1  asynchronous active-low reset.
- SW  input  18  SW[1:0] requested mode, SW[3:2] speed, SW[4] run enable, SW[5] restart; SW[17:6] unused.
- led  output  18  LED pattern, registered.
- mode  output  2  currently active mode, registered.
- step  output  1  one-cycle pulse, coincident with each led update.
- cycle_done  output  1  one-cycle pulse when the active pattern returns to its start state.

Behaviour:
- Reset, async on Resetn=0:
  - prescaler=0, mode=00, pos=0, dir=up, phase=A.
  - led=18'h00001, step=0, cycle_done=0.
- Period P = DIV_BASE << (3-SW[3:2]), giving 8x/4x/2x/1x DIV_BASE. P is re-evaluated every cycle.
- Prescaler:
  - SW[4]=1: increments each clock. When count >= P-1, it clears and a step fires at that edge.
  - The >= comparison covers a speed change to a shorter P.
  - SW[4]=0: prescaler, pos and led hold; no step and no cycle_done.
- On a step, led, pos, dir, phase and step=1 update at the same edge. Otherwise step=0.
- Modes and start states:
  - 00 LEFT: single lit LED, pos increments; 17 wraps to 0. Start state pos=0.
  - 01 RIGHT: single lit LED, pos decrements; 0 wraps to 17. Start state pos=17.
  - 10 BOUNCE: pos 0→17→0 with dir flipping at the ends and no repeated endpoint (…16,17,16…1,0,1…). Start state pos=0, dir=up.
  - 11 INVERT: led alternates 18'h15555 (phase A) and 18'h2AAAA (phase B). Start state phase A.
- Boundary and mode change:
  - A step whose next state equals the active mode's start state is a boundary. cycle_done=1 at that edge.
  - At a boundary, if SW[1:0] differs from mode, load mode=SW[1:0] and that mode's start state instead. cycle_done still pulses.
  - SW[1:0] changes between boundaries are ignored until the next boundary; the last value sampled wins.
- Restart:
  - SW[5]=1 (level): at the next edge, load mode=SW[1:0] and its start state, clear the prescaler, step=0, cycle_done=0.
  - Restart is held while SW[5]=1 and has priority over steps.
  - Restart takes effect even when SW[4]=0.
- Output encoding:
  - LEFT, RIGHT, BOUNCE: led = one-hot of pos.
  - INVERT: led as above.
  - led always reflects the current state registers; no stale bits are left behind.
- Reset mid-step: immediate return to reset values; no pulse is emitted.

Test Plan:
- Reset, DIV_BASE=4, SW=18'h0001C (LEFT, fastest P=4, run) → step every 4 clocks; led 00001,00002,…,20000,00001. cycle_done pulses with the 20000→00001 update.
- Start as above, set SW[1:0]=01 at pos=5 → LEFT continues to pos 17. At the wrap edge led=20000 (RIGHT start), mode=01, cycle_done=1. Next steps give 10000, 08000.
- BOUNCE (SW=18'h0001E) → led sequence 00001…20000,10000…00001,00002. cycle_done fires only on return to pos 0, with led=00001 on that edge.
- INVERT (SW=18'h0001F) after restart → led 15555 then 2AAAA, 15555 each step. cycle_done on every return to 15555.
- SW[3:2]=00 (P=32), then change to 11 when count=20 → step on the next clock (count>=3). Subsequent steps every 4 clocks.
- Clear SW[4] mid-pattern for 100 clocks → led frozen, no step. Pulse SW[5] with SW[1:0]=01 while disabled → led=20000, mode=01. Assert Resetn=0 mid-run → led=00001, mode=00 immediately.
